// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// sources, with a one-entry registered writeback stage and a pending-write scoreboard.
module wb_port_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [NREQ-1:0]      req_fp,
    input  logic [XLEN*NREQ-1:0] req_data,
    input  logic                 Stall,
    output logic                 WE_reg,
    output logic                 WE_freg,
    output logic [4:0]           rd_addr_ex,
    output logic [XLEN-1:0]      reg_write_data,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_rd,
    input  logic                 iss_fp,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    input  logic                 chk_fp,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 hazard,
    output logic                 waw_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR = NREQ;

    logic            wb_valid;
    logic            wb_fp;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [PW-1:0]   rr_ptr;

    logic            can_load;
    logic            commit;
    logic            gnt_found;
    logic            grant;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    int unsigned     cand_sum;
    logic [4:0]      sel_rd;
    logic            sel_fp;
    logic [XLEN-1:0] sel_data;

    logic [31:0] pend_x, pend_f;
    logic [31:0] set_x, set_f, clr_x, clr_f;
    logic        waw_hit;

    assign can_load = ~wb_valid | ~Stall;
    assign commit   = wb_valid & ~Stall;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        cand_sum  = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand_sum = (32'(rr_ptr) + k) % NR;
            cand     = PW'(cand_sum);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign grant = gnt_found & can_load;

    // Ready is held low during reset so no requester sees a handshake that is dropped.
    always_comb begin
        req_ready = '0;
        if (grant && RST_N) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_rd   = '0;
        sel_fp   = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_rd   = req_rd[5*i +: 5];
                sel_fp   = req_fp[i];
                sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    always_comb begin
        set_x = '0;
        set_f = '0;
        clr_x = '0;
        clr_f = '0;
        if (iss_valid) begin
            if (iss_fp)              set_f[iss_rd] = 1'b1;
            else if (iss_rd != 5'd0) set_x[iss_rd] = 1'b1;
        end
        if (commit) begin
            if (wb_fp) clr_f[wb_rd] = 1'b1;
            else       clr_x[wb_rd] = 1'b1;
        end
        waw_hit = |((set_x & pend_x & ~clr_x) | (set_f & pend_f & ~clr_f));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wb_valid <= 1'b0;
            wb_fp    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            rr_ptr   <= PW'(NR - 1);
            pend_x   <= '0;
            pend_f   <= '0;
            waw_err  <= 1'b0;
        end else begin
            if (grant) begin
                wb_valid <= 1'b1;
                wb_rd    <= sel_rd;
                wb_fp    <= sel_fp;
                wb_data  <= sel_data;
                rr_ptr   <= gnt_idx;
            end else if (commit) begin
                wb_valid <= 1'b0;
            end
            // Set is applied after clear so an issue wins over a same-cycle commit.
            pend_x <= (pend_x & ~clr_x) | set_x;
            pend_f <= (pend_f & ~clr_f) | set_f;
            if (waw_hit) waw_err <= 1'b1;
        end
    end

    assign WE_reg         = wb_valid & ~wb_fp & (wb_rd != 5'd0);
    assign WE_freg        = wb_valid & wb_fp;
    assign rd_addr_ex     = wb_rd;
    assign reg_write_data = wb_data;

    assign rs1_busy = chk_fp ? pend_f[rs1_addr] : pend_x[rs1_addr];
    assign rs2_busy = chk_fp ? pend_f[rs2_addr] : pend_x[rs2_addr];
    assign hazard   = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter: requesters hold requests until granted and a
// behavioural model predicts grants, write-port outputs and scoreboard state each cycle.
module tb_wb_port_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 CLK = 1'b0;
    logic                 RST_N = 1'b1;
    logic [NREQ-1:0]      req_valid, req_ready, req_fp;
    logic [5*NREQ-1:0]    req_rd;
    logic [XLEN*NREQ-1:0] req_data;
    logic                 Stall, WE_reg, WE_freg;
    logic [4:0]           rd_addr_ex;
    logic [XLEN-1:0]      reg_write_data;
    logic                 iss_valid, iss_fp, chk_fp;
    logic [4:0]           iss_rd, rs1_addr, rs2_addr;
    logic                 rs1_busy, rs2_busy, hazard, waw_err;

    always #5 CLK = ~CLK;

    wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_fp(req_fp), .req_data(req_data), .Stall(Stall),
        .WE_reg(WE_reg), .WE_freg(WE_freg), .rd_addr_ex(rd_addr_ex),
        .reg_write_data(reg_write_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_fp(iss_fp), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .chk_fp(chk_fp),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .hazard(hazard), .waw_err(waw_err)
    );

    // Requester side: each source keeps its request until it is accepted.
    bit              r_v  [NREQ];
    int              r_rd [NREQ];
    bit              r_fp [NREQ];
    logic [XLEN-1:0] r_d  [NREQ];

    // Reference model state.
    bit              m_v, m_fp, m_waw;
    int              m_rd, m_last;
    logic [XLEN-1:0] m_d;
    bit              pend [2][32];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_fp = 0; m_rd = 0; m_d = '0; m_last = NREQ - 1; m_waw = 0;
        foreach (pend[f, r]) pend[f][r] = 0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]              = r_v[i];
            req_fp[i]                 = r_fp[i];
            req_rd[5*i +: 5]          = 5'(r_rd[i]);
            req_data[XLEN*i +: XLEN]  = r_d[i];
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_WE_reg", WE_reg, 0);
        check_eq("rst_WE_freg", WE_freg, 0);
        check_eq("rst_rd_addr", rd_addr_ex, 0);
        check_eq("rst_wr_data", reg_write_data, 0);
        check_eq("rst_rs1_busy", rs1_busy, 0);
        check_eq("rst_rs2_busy", rs2_busy, 0);
        check_eq("rst_hazard", hazard, 0);
        check_eq("rst_waw_err", waw_err, 0);
    endtask

    // Called at a falling edge: drive, check, advance the model, wait for the next falling edge.
    task automatic cycle(input int pv, input int ps, input int pi);
        int g, j;
        bit can_load, commit, b1, b2;
        logic [NREQ-1:0] exp_rdy;
        for (int i = 0; i < NREQ; i++) begin
            if (!r_v[i] && $urandom_range(99) < pv) begin
                r_v[i] = 1; r_rd[i] = $urandom_range(7); r_fp[i] = 1'($urandom_range(1)); r_d[i] = $urandom;
            end
        end
        drive_reqs();
        Stall     = ($urandom_range(99) < ps);
        iss_valid = ($urandom_range(99) < pi);
        iss_rd    = 5'($urandom_range(7));
        iss_fp    = 1'($urandom_range(1));
        rs1_addr  = 5'($urandom_range(7));
        rs2_addr  = 5'($urandom_range(7));
        chk_fp    = 1'($urandom_range(1));
        #1;
        can_load = !m_v || !Stall;
        g = -1;
        if (can_load) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (m_last + k) % NREQ;
                if (g < 0 && r_v[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        b1 = pend[chk_fp][rs1_addr];
        b2 = pend[chk_fp][rs2_addr];
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("WE_reg", WE_reg, m_v && !m_fp && m_rd != 0);
        check_eq("WE_freg", WE_freg, m_v && m_fp);
        check_eq("rd_addr_ex", rd_addr_ex, m_rd);
        check_eq("reg_write_data", reg_write_data, m_d);
        check_eq("rs1_busy", rs1_busy, b1);
        check_eq("rs2_busy", rs2_busy, b2);
        check_eq("hazard", hazard, b1 | b2);
        check_eq("waw_err", waw_err, m_waw);

        commit = m_v && !Stall;
        if (iss_valid && (iss_fp || iss_rd != 0) && pend[iss_fp][iss_rd]
            && !(commit && m_fp == iss_fp && m_rd == iss_rd))
            m_waw = 1;
        if (commit) pend[m_fp][m_rd] = 0;
        if (iss_valid && (iss_fp || iss_rd != 0)) pend[iss_fp][iss_rd] = 1;
        if (g >= 0) begin
            m_v = 1; m_rd = r_rd[g]; m_fp = r_fp[g]; m_d = r_d[g]; m_last = g; r_v[g] = 0;
        end else if (commit) begin
            m_v = 0;
        end
        @(negedge CLK);
    endtask

    initial begin
        foreach (r_v[i]) begin r_v[i] = 0; r_rd[i] = 0; r_fp[i] = 0; r_d[i] = '0; end
        drive_reqs();
        Stall = 0; iss_valid = 0; iss_rd = '0; iss_fp = 0;
        rs1_addr = '0; rs2_addr = '0; chk_fp = 0;
        model_reset();
        #1 RST_N = 1'b0;
        @(negedge CLK);
        #1 check_reset_outputs();
        @(negedge CLK);
        RST_N = 1'b1;

        // Single ALU write of x5.
        r_v[0] = 1; r_rd[0] = 5; r_fp[0] = 0; r_d[0] = 32'h1234;
        repeat (3) cycle(0, 0, 0);

        // FPU write of f7 held by a stall while another source waits.
        r_v[2] = 1; r_rd[2] = 7; r_fp[2] = 1; r_d[2] = 32'hCAFE_F007;
        cycle(0, 0, 0);
        r_v[0] = 1; r_rd[0] = 3; r_fp[0] = 0; r_d[0] = 32'h0000_0303;
        repeat (3) cycle(0, 100, 0);
        repeat (3) cycle(0, 0, 0);

        // All sources valid continuously: strict rotation.
        repeat (30) cycle(100, 0, 30);

        repeat (300) cycle(60, 25, 40);

        // Reset mid-operation with requests outstanding.
        RST_N = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;

        repeat (300) cycle(70, 30, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
